nq_accumulator: RTL

//   Downstream stage of the NQ sign-magnitude multiplier. It sums NR_OF_TERMS_P consecutive

---
 rtl/nq_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nq_accumulator.sv
// Sums NR_OF_TERMS_P sign-magnitude NQ products per frame into a wide signed accumulator.
// It emits one saturated sign-magnitude result per frame through a one-deep valid/ready register.
module nq_accumulator #(
    parameter int N_BITS_P      = 32,
    parameter int Q_BITS_P      = 15,
    parameter int NR_OF_TERMS_P = 16,
    parameter int ACC_BITS_P    = N_BITS_P + $clog2(NR_OF_TERMS_P) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ing_valid,
    output logic                ing_ready,
    input  logic [N_BITS_P-1:0] ing_product,
    input  logic                ing_overflow,
    output logic                egr_valid,
    input  logic                egr_ready,
    output logic [N_BITS_P-1:0] egr_sum,
    output logic                egr_overflow,
    output logic                sr_dropped
);

    localparam int CNT_W = $clog2(NR_OF_TERMS_P);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NR_OF_TERMS_P - 1);
    localparam logic [ACC_BITS_P-1:0] MAX_C = {{(ACC_BITS_P-N_BITS_P+1){1'b0}}, {(N_BITS_P-1){1'b1}}};

    if (NR_OF_TERMS_P < 2 || Q_BITS_P >= N_BITS_P) begin : g_bad_params
        $error("nq_accumulator: NR_OF_TERMS_P must be >= 2 and Q_BITS_P < N_BITS_P");
    end

    // Sign-magnitude to two's complement; -0 naturally maps to 0.
    function automatic logic signed [ACC_BITS_P-1:0] to_acc(input logic [N_BITS_P-1:0] p);
        logic signed [ACC_BITS_P-1:0] mag;
        mag = $signed({{(ACC_BITS_P-N_BITS_P+1){1'b0}}, p[N_BITS_P-2:0]});
        if (p[N_BITS_P-1]) begin
            to_acc = -mag;
        end else begin
            to_acc = mag;
        end
    endfunction

    // Returns {saturated, sign, magnitude}; a zero sum always carries sign 0.
    function automatic logic [N_BITS_P:0] to_nq(input logic signed [ACC_BITS_P-1:0] s);
        logic [ACC_BITS_P-1:0] abs_v;
        logic                  sign_v;
        sign_v = s[ACC_BITS_P-1];
        if (sign_v) begin
            abs_v = ACC_BITS_P'(-s);
        end else begin
            abs_v = ACC_BITS_P'(s);
        end
        if (abs_v > MAX_C) begin
            to_nq = {1'b1, sign_v, {(N_BITS_P-1){1'b1}}};
        end else begin
            to_nq = {1'b0, sign_v, abs_v[N_BITS_P-2:0]};
        end
    endfunction

    logic signed [ACC_BITS_P-1:0] acc_r;
    logic [CNT_W-1:0]             cnt_r;
    logic                         frame_ovf_r;
    logic                         alive_r;
    logic                         egr_valid_r;
    logic [N_BITS_P-1:0]          egr_sum_r;
    logic                         egr_overflow_r;
    logic                         sr_dropped_r;

    logic                         last_s;
    logic                         take_s;
    logic signed [ACC_BITS_P-1:0] sum_s;
    logic [N_BITS_P:0]            res_s;

    // The last term is only refused when the result slot stays occupied through this cycle.
    assign last_s    = (cnt_r == LAST_C);
    assign ing_ready = alive_r && !(egr_valid_r && last_s && !egr_ready);
    assign take_s    = ing_valid && ing_ready;
    assign sum_s     = acc_r + to_acc(ing_product);
    assign res_s     = to_nq(sum_s);

    // Frame accumulation: sum, term counter and frame overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            frame_ovf_r <= 1'b0;
            alive_r     <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (take_s && last_s) begin
                acc_r       <= '0;
                cnt_r       <= '0;
                frame_ovf_r <= 1'b0;
            end else if (take_s) begin
                acc_r       <= sum_s;
                cnt_r       <= cnt_r + CNT_W'(1);
                frame_ovf_r <= frame_ovf_r | ing_overflow;
            end else begin
                acc_r       <= acc_r;
                cnt_r       <= cnt_r;
                frame_ovf_r <= frame_ovf_r;
            end
        end
    end

    // Result register; a completing frame overwrites a result handed off in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            egr_valid_r    <= 1'b0;
            egr_sum_r      <= '0;
            egr_overflow_r <= 1'b0;
        end else if (take_s && last_s) begin
            egr_valid_r    <= 1'b1;
            egr_sum_r      <= res_s[N_BITS_P-1:0];
            egr_overflow_r <= frame_ovf_r | ing_overflow | res_s[N_BITS_P];
        end else if (egr_valid_r && egr_ready) begin
            egr_valid_r    <= 1'b0;
        end else begin
            egr_valid_r    <= egr_valid_r;
        end
    end

    // Sticky record of products offered while refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_dropped_r <= 1'b0;
        end else if (ing_valid && !ing_ready) begin
            sr_dropped_r <= 1'b1;
        end else begin
            sr_dropped_r <= sr_dropped_r;
        end
    end

    assign egr_valid    = egr_valid_r;
    assign egr_sum      = egr_sum_r;
    assign egr_overflow = egr_overflow_r;
    assign sr_dropped   = sr_dropped_r;

endmodule
